// File: rtl/incenter_stream_tx_pkg.sv
// Shared constants and FSM encoding for the incenter input-stream transmitter.
package incenter_stream_tx_pkg;

  localparam int DATA_W = 17;
  localparam int WORDS  = 9;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/incenter_rec_fifo.sv
// Two-entry record buffer; exposes the head and the entry behind it so the
// sender can start the next record on the same edge that retires the head.
module incenter_rec_fifo #(
  parameter int W = 153
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] next_head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head      = mem[rd_ptr];
  assign next_head = mem[~rd_ptr];

endmodule

// File: rtl/incenter_stream_tx.sv
// Serializes buffered triangle records into nine-word bursts for the incenter
// core's IN_DATA/IN_VALID stream, with an optional idle gap between records.
module incenter_stream_tx
  import incenter_stream_tx_pkg::*;
#(
  parameter int DATA_W = incenter_stream_tx_pkg::DATA_W,
  parameter int WORDS  = incenter_stream_tx_pkg::WORDS,
  parameter int GAP    = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REC_VALID,
  output logic                    REC_READY,
  input  logic [WORDS*DATA_W-1:0] REC_DATA,
  output logic [DATA_W-1:0]       TX_DATA,
  output logic                    TX_VALID,
  output logic                    TX_LAST,
  output logic [7:0]              REC_SENT,
  output logic                    BUSY
);

  localparam int                GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t                  state, nxt_state;
  logic [IDX_W-1:0]        idx, nxt_idx, idx_p1;
  logic [3:0]              gap_cnt, nxt_gap;
  logic [WORDS*DATA_W-1:0] head, next_head;
  logic [1:0]              count, count_nxt;
  logic                    push, pop;
  logic [DATA_W-1:0]       nxt_data;
  logic                    nxt_valid, nxt_last;
  logic [DATA_W-1:0]       head_w [WORDS];
  logic [DATA_W-1:0]       nh_w   [WORDS];

  // Ready looks only at the registered count: a slot freed this edge is not reusable until next cycle.
  assign REC_READY = (count < 2'd2);
  assign push      = REC_VALID && REC_READY;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign idx_p1    = idx + 1'b1;

  incenter_rec_fifo #(.W(WORDS*DATA_W)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data (REC_DATA),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count)
  );

  for (genvar k = 0; k < WORDS; k++) begin : g_word
    assign head_w[k] = head[k*DATA_W +: DATA_W];
    assign nh_w[k]   = next_head[k*DATA_W +: DATA_W];
  end

  // Next-cycle outputs are decided here and registered below; idx names the word on TX_DATA.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_gap   = gap_cnt;
    nxt_data  = '0;
    nxt_valid = 1'b0;
    nxt_last  = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != 2'd0) begin
          nxt_state = ST_SEND;
          nxt_idx   = '0;
          nxt_valid = 1'b1;
          nxt_data  = head_w[0];
        end
      end
      ST_SEND: begin
        if (idx == LAST_IDX) begin
          pop = 1'b1;
          if (GAP > 0) begin
            nxt_state = ST_GAP;
            nxt_gap   = 4'(GAP_M1);
          end else if (count == 2'd2) begin
            // Second record already buffered: start it with no bubble.
            nxt_state = ST_SEND;
            nxt_idx   = '0;
            nxt_valid = 1'b1;
            nxt_data  = nh_w[0];
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_idx   = idx_p1;
          nxt_valid = 1'b1;
          nxt_data  = head_w[idx_p1];
          nxt_last  = (idx_p1 == LAST_IDX);
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (count != 2'd0) begin
            nxt_state = ST_SEND;
            nxt_idx   = '0;
            nxt_valid = 1'b1;
            nxt_data  = head_w[0];
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_gap = gap_cnt - 4'd1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      idx      <= '0;
      gap_cnt  <= 4'd0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      TX_LAST  <= 1'b0;
      REC_SENT <= 8'd0;
      BUSY     <= 1'b0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      gap_cnt  <= nxt_gap;
      TX_DATA  <= nxt_data;
      TX_VALID <= nxt_valid;
      TX_LAST  <= nxt_last;
      if (pop) REC_SENT <= REC_SENT + 8'd1;
      BUSY     <= (count_nxt != 2'd0) || (nxt_state != ST_IDLE);
    end
  end

endmodule
